ad5781_model: RTL and testbench

AD5781_MODEL -- requirements
Module: ad5781_model

---
 rtl/ad5781_model.sv | 201 ++++++++++++++++++++
 tb/tb_ad5781_model.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad5781_model.sv
// ---------------------------------------------------------------------------
// ad5781_model
//
// Behavioural, synthesizable model of an AD5781-style 18-bit DAC serial
// interface. Every pin is brought into the clk domain through a
// SYNC_STAGES-deep synchronizer. All edge detection uses the synchronized
// values. A 24-bit frame is shifted in on sclk falling edges while syncn is
// low. The frame commits on syncn rising, but only if exactly 24 bits
// arrived. A committed read frame queues a response. That response is shifted
// out on sdo during the following frame.
//
// Ports:
//   clk     - system clock, at least 4x the sclk frequency
//   rst     - synchronous active-high reset
//   sdin    - serial data in, MSB first
//   sclk    - SPI clock (asynchronous to clk)
//   syncn   - active-low frame select
//   ldacn   - active-low load-DAC pin (level at commit, falling edge)
//   clrn    - active-low clear pin (falling edge only)
//   resetn  - active-low device reset pin (level-sensitive)
//   sdo     - serial readback data
//   vout    - modelled 18-bit DAC output code
// ---------------------------------------------------------------------------
module ad5781_model #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sdin,
   input  logic        sclk,
   input  logic        syncn,
   input  logic        ldacn,
   input  logic        clrn,
   input  logic        resetn,
   output logic        sdo,
   output logic [17:0] vout
);

   localparam logic [19:0] CTRL_RESET = 20'h0000C;

   // Pin order inside the synchronizer bundle:
   // {resetn, clrn, ldacn, syncn, sclk, sdin}
   logic [5:0] pins;
   logic [5:0] sync_chain [SYNC_STAGES];
   logic [5:0] pin_s;
   logic [3:0] edge_prev;

   logic sdin_s, sclk_s, syncn_s, ldacn_s, clrn_s, resetn_s;
   logic sclk_fall, sclk_rise, syncn_fall, syncn_rise, ldacn_fall, clrn_fall;

   logic [17:0] in_reg;
   logic [17:0] dac_reg;
   logic [17:0] clear_code;
   logic [19:0] ctrl_reg;
   logic [23:0] shift_reg;
   logic [4:0]  bit_cnt;
   logic        frame_active;
   logic [23:0] tx_reg;
   logic        tx_pending;
   logic        tx_active;

   logic [2:0]  addr;
   logic [19:0] data;
   logic        commit;
   logic        soft_reset;
   logic        do_reset;
   logic [19:0] read_data;

   assign pins = {resetn, clrn, ldacn, syncn, sclk, sdin};

   // The synchronizers and the edge history are never reset. They keep
   // tracking the pins through reset, so releasing reset cannot produce a
   // phantom edge.
   always_ff @(posedge clk) begin
      sync_chain[0] <= pins;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_chain[i] <= sync_chain[i-1];
      end
      edge_prev <= sync_chain[SYNC_STAGES-1][4:1];
   end

   assign pin_s    = sync_chain[SYNC_STAGES-1];
   assign sdin_s   = pin_s[0];
   assign sclk_s   = pin_s[1];
   assign syncn_s  = pin_s[2];
   assign ldacn_s  = pin_s[3];
   assign clrn_s   = pin_s[4];
   assign resetn_s = pin_s[5];

   assign sclk_fall  =  edge_prev[0] & ~sclk_s;
   assign sclk_rise  = ~edge_prev[0] &  sclk_s;
   assign syncn_fall =  edge_prev[1] & ~syncn_s;
   assign syncn_rise = ~edge_prev[1] &  syncn_s;
   assign ldacn_fall =  edge_prev[2] & ~ldacn_s;
   assign clrn_fall  =  edge_prev[3] & ~clrn_s;

   assign addr   = shift_reg[22:20];
   assign data   = shift_reg[19:0];
   assign commit = syncn_rise & frame_active & (bit_cnt == 5'd24);

   // A software-control write with bit2 set is handled exactly like a pin
   // reset. It therefore outranks the CLR and LDAC bits in the same word.
   assign soft_reset = commit & ~shift_reg[23] & (addr == 3'b100) & shift_reg[2];
   assign do_reset   = rst | ~resetn_s | soft_reset;

   // Register contents as seen by a read. The 18-bit registers are
   // left-justified into the 20-bit data field.
   always_comb begin
      read_data = '0;
      case (addr)
         3'b001:  read_data = {in_reg, 2'b00};
         3'b010:  read_data = ctrl_reg;
         3'b011:  read_data = {clear_code, 2'b00};
         default: read_data = '0;
      endcase
   end

   // Main state update. Frame handling, pin events and command decode all
   // live here. Statements later in the block win when two events land in
   // the same cycle, so a frame commit overrides a coincident pin edge.
   always_ff @(posedge clk) begin
      if (do_reset) begin
         in_reg       <= '0;
         dac_reg      <= '0;
         clear_code   <= '0;
         ctrl_reg     <= CTRL_RESET;
         shift_reg    <= '0;
         bit_cnt      <= '0;
         frame_active <= 1'b0;
         tx_reg       <= '0;
         tx_pending   <= 1'b0;
         tx_active    <= 1'b0;
      end else begin
         if (ldacn_fall) begin
            dac_reg <= in_reg;
         end
         if (clrn_fall) begin
            in_reg  <= clear_code;
            dac_reg <= clear_code;
         end

         // A pending read response is claimed by the next frame, whether or
         // not that frame itself commits. The bit counter saturates, so an
         // overlong frame can never wrap back to a valid length.
         if (syncn_fall) begin
            shift_reg    <= '0;
            bit_cnt      <= '0;
            frame_active <= 1'b1;
            tx_active    <= tx_pending;
            tx_pending   <= 1'b0;
         end else if (sclk_fall && frame_active && !syncn_s) begin
            shift_reg <= {shift_reg[22:0], sdin_s};
            if (bit_cnt != 5'd31) begin
               bit_cnt <= bit_cnt + 5'd1;
            end
         end

         if (sclk_rise && tx_active) begin
            tx_reg <= {tx_reg[22:0], 1'b0};
         end

         if (syncn_rise) begin
            frame_active <= 1'b0;
            tx_active    <= 1'b0;
         end

         if (commit) begin
            if (shift_reg[23]) begin
               tx_reg     <= {1'b1, addr, read_data};
               tx_pending <= 1'b1;
            end else begin
               case (addr)
                  3'b001: begin
                     in_reg <= data[19:2];
                     if (!ldacn_s) begin
                        dac_reg <= data[19:2];
                     end
                  end
                  3'b010: ctrl_reg   <= data;
                  3'b011: clear_code <= data[19:2];
                  3'b100: begin
                     if (data[1]) begin
                        in_reg  <= clear_code;
                        dac_reg <= clear_code;
                     end else if (data[0]) begin
                        dac_reg <= in_reg;
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   // OPGND (bit2) or DACTRI (bit3) grounds the output. SDODIS (bit5) mutes
   // sdo.
   assign vout = (ctrl_reg[2] | ctrl_reg[3]) ? 18'd0 : dac_reg;
   assign sdo  = tx_active & ~ctrl_reg[5] & tx_reg[23];

endmodule

// File: tb/tb_ad5781_model.sv
// ---------------------------------------------------------------------------
// tb_ad5781_model
//
// Self-checking bench for ad5781_model. Serial frames are driven with sclk
// running 16x slower than clk. A register-level reference model tracks the
// expected input, DAC, clearcode and control registers, plus any pending
// read response.
// ---------------------------------------------------------------------------
module tb_ad5781_model;

   localparam int SYNC_STAGES = 2;
   localparam int HALF        = 8;

   logic        clk = 1'b0;
   logic        rst, sdin, sclk, syncn, ldacn, clrn, resetn;
   logic        sdo;
   logic [17:0] vout;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [17:0] m_in, m_dac, m_cc;
   logic [19:0] m_ctrl;
   logic [23:0] m_resp;
   logic        m_pending;

   always #5 clk = ~clk;

   ad5781_model #(.SYNC_STAGES(SYNC_STAGES)) dut (
      .clk(clk), .rst(rst), .sdin(sdin), .sclk(sclk), .syncn(syncn),
      .ldacn(ldacn), .clrn(clrn), .resetn(resetn), .sdo(sdo), .vout(vout)
   );

   // ---------------- reference model ----------------
   function automatic void model_reset();
      m_in = '0; m_dac = '0; m_cc = '0; m_ctrl = 20'h0000C;
      m_resp = '0; m_pending = 1'b0;
   endfunction

   function automatic logic [17:0] model_vout();
      return (m_ctrl[2] || m_ctrl[3]) ? 18'd0 : m_dac;
   endfunction

   function automatic logic [19:0] model_read(input logic [2:0] a);
      if (a == 3'b001) return {m_in, 2'b00};
      if (a == 3'b010) return m_ctrl;
      if (a == 3'b011) return {m_cc, 2'b00};
      return 20'd0;
   endfunction

   function automatic logic [23:0] model_frame_start();
      logic [23:0] e;
      e = (m_pending && !m_ctrl[5]) ? m_resp : 24'd0;
      m_pending = 1'b0;
      return e;
   endfunction

   function automatic void model_commit(input logic [23:0] w, input logic ldac_low);
      logic [2:0]  a;
      logic [19:0] d;
      a = w[22:20];
      d = w[19:0];
      if (w[23]) begin
         m_resp    = {1'b1, a, model_read(a)};
         m_pending = 1'b1;
      end else if (a == 3'b001) begin
         m_in = d[19:2];
         if (ldac_low) m_dac = d[19:2];
      end else if (a == 3'b010) begin
         m_ctrl = d;
      end else if (a == 3'b011) begin
         m_cc = d[19:2];
      end else if (a == 3'b100) begin
         if (d[2]) model_reset();
         else if (d[1]) begin m_in = m_cc; m_dac = m_cc; end
         else if (d[0]) m_dac = m_in;
      end
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic frame_begin();
      syncn = 1'b0;
      wait_clks(HALF);
   endtask

   task automatic shift_bit(input logic b, output logic s);
      sdin = b;
      wait_clks(HALF);
      s    = sdo;
      sclk = 1'b0;
      wait_clks(HALF);
      sclk = 1'b1;
   endtask

   task automatic frame_end();
      wait_clks(HALF);
      syncn = 1'b1;
      wait_clks(HALF);
   endtask

   task automatic xfer(input logic [23:0] w, input int nbits,
                       output logic [23:0] exp_sdo, output logic [23:0] got_sdo);
      logic b;
      exp_sdo = model_frame_start();
      got_sdo = '0;
      frame_begin();
      for (int i = 0; i < nbits; i++) begin
         shift_bit(w[23-i], b);
         got_sdo[23-i] = b;
      end
      frame_end();
      if (nbits == 24) model_commit(w, !ldacn);
   endtask

   task automatic set_ldacn(input logic v);
      if (ldacn && !v) m_dac = m_in;
      ldacn = v;
      wait_clks(6);
   endtask

   function automatic logic [23:0] wr_code(input logic [2:0] a, input logic [17:0] c);
      return {1'b0, a, c, 2'b00};
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      wait_clks(10);
      rst = 1'b0;
      model_reset();
      wait_clks(4);
      checks++;
      if (vout !== 18'd0) begin
         errors++; $display("[TB] FAIL reset_vout: got %h expected %h", vout, 18'd0);
      end
      checks++;
      if (sdo !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_sdo: got %b expected 0", sdo);
      end
   endtask

   task automatic test_control_write();
      logic [23:0] e, g;
      set_ldacn(1'b0);
      xfer(24'h200002, 24, e, g);
      checks++;
      if (vout !== 18'd0) begin
         errors++; $display("[TB] FAIL ctrl_vout: got %h expected %h", vout, 18'd0);
      end
      xfer(24'hA00000, 24, e, g);
      xfer(24'h000000, 24, e, g);
      checks++;
      if (g !== 24'hA00002 || g !== e) begin
         errors++; $display("[TB] FAIL ctrl_readback: got %h expected %h", g, 24'hA00002);
      end
   endtask

   task automatic test_direct_load();
      logic [23:0] e, g;
      xfer(wr_code(3'b001, 18'h3DEAD), 24, e, g);
      checks++;
      if (vout !== 18'h3DEAD || vout !== model_vout()) begin
         errors++; $display("[TB] FAIL direct_load: got %h expected %h", vout, 18'h3DEAD);
      end
   endtask

   task automatic test_ldac_pin();
      logic [23:0] e, g;
      set_ldacn(1'b1);
      xfer(wr_code(3'b001, 18'h12345), 24, e, g);
      checks++;
      if (vout !== 18'h3DEAD) begin
         errors++; $display("[TB] FAIL ldac_hold: got %h expected %h", vout, 18'h3DEAD);
      end
      // The synchronized edge is seen after SYNC_STAGES clocks. vout follows
      // one clock later.
      ldacn = 1'b0;
      m_dac = m_in;
      repeat (SYNC_STAGES) @(posedge clk);
      #1;
      checks++;
      if (vout !== 18'h3DEAD) begin
         errors++; $display("[TB] FAIL ldac_early: got %h expected %h", vout, 18'h3DEAD);
      end
      @(posedge clk);
      #1;
      checks++;
      if (vout !== 18'h12345 || vout !== model_vout()) begin
         errors++; $display("[TB] FAIL ldac_edge: got %h expected %h", vout, 18'h12345);
      end
      wait_clks(4);
   endtask

   task automatic test_short_frame();
      logic [23:0] e, g;
      xfer(wr_code(3'b001, 18'($urandom)), 23, e, g);
      checks++;
      if (vout !== 18'h12345) begin
         errors++; $display("[TB] FAIL short_vout: got %h expected %h", vout, 18'h12345);
      end
      xfer(24'h900000, 24, e, g);
      xfer(24'h000000, 24, e, g);
      checks++;
      if (g !== e || g !== 24'h948D14) begin
         errors++; $display("[TB] FAIL short_readback: got %h expected %h", g, 24'h948D14);
      end
   endtask

   task automatic test_clear();
      logic [23:0] e, g;
      xfer(wr_code(3'b011, 18'h00100), 24, e, g);
      clrn = 1'b0;
      m_in = m_cc; m_dac = m_cc;
      wait_clks(8);
      checks++;
      if (vout !== 18'h00100 || vout !== model_vout()) begin
         errors++; $display("[TB] FAIL clear_pin: got %h expected %h", vout, 18'h00100);
      end
      clrn = 1'b1;
      wait_clks(6);
   endtask

   task automatic test_sdodis();
      logic [23:0] e, g;
      xfer(24'h200022, 24, e, g);
      xfer(24'hA00000, 24, e, g);
      xfer(24'h000000, 24, e, g);
      checks++;
      if (g !== 24'd0 || g !== e) begin
         errors++; $display("[TB] FAIL sdodis: got %h expected %h", g, 24'd0);
      end
      xfer(24'h200002, 24, e, g);
   endtask

   task automatic test_sw_control();
      logic [23:0] e, g;
      for (int k = 0; k < 8; k++) begin
         set_ldacn(1'b1);
         xfer(wr_code(3'b011, 18'($urandom)), 24, e, g);
         xfer(wr_code(3'b001, 18'($urandom)), 24, e, g);
         xfer({1'b0, 3'b100, 17'd0, 3'(k)}, 24, e, g);
         checks++;
         if (vout !== model_vout()) begin
            errors++; $display("[TB] FAIL sw_ctrl_%0d: got %h expected %h", k, vout, model_vout());
         end
         if (k[2]) xfer(24'h200002, 24, e, g);
      end
   endtask

   task automatic test_random();
      logic [23:0] e, g, w;
      logic [2:0]  a;
      logic [19:0] d;
      int          r;
      for (int n = 0; n < 40; n++) begin
         set_ldacn(1'($urandom));
         r = $urandom_range(9);
         d = 20'($urandom);
         if (r <= 2) a = 3'b001;
         else if (r <= 4) a = 3'b010;
         else if (r == 5) a = 3'b011;
         else if (r == 6) a = 3'b100;
         else if (r == 7) a = 3'b000;
         else a = 3'($urandom_range(7, 5));
         if (a == 3'b010 && $urandom_range(3) != 0) d[3:2] = 2'b00;
         if (a == 3'b100 && $urandom_range(3) != 0) d[2] = 1'b0;
         w = {1'b0, a, d};
         if (r == 9) w = {1'b1, 3'($urandom), 20'd0};
         xfer(w, 24, e, g);
         checks++;
         if (g !== e) begin
            errors++; $display("[TB] FAIL rand_sdo_%0d: got %h expected %h", n, g, e);
         end
         checks++;
         if (vout !== model_vout()) begin
            errors++; $display("[TB] FAIL rand_vout_%0d: got %h expected %h", n, vout, model_vout());
         end
         if ($urandom_range(7) == 0) begin
            clrn = 1'b0;
            m_in = m_cc; m_dac = m_cc;
            wait_clks(6);
            clrn = 1'b1;
            wait_clks(6);
            checks++;
            if (vout !== model_vout()) begin
               errors++; $display("[TB] FAIL rand_clr_%0d: got %h expected %h", n, vout, model_vout());
            end
         end
      end
   endtask

   task automatic test_resetn_midframe();
      logic [23:0] e, g, w;
      logic [17:0] code;
      logic        b;
      set_ldacn(1'b0);
      xfer(24'h200002, 24, e, g);
      // The interrupted frame is a complete, valid-length input write. It
      // must still be dropped because the reset cut into it.
      w = wr_code(3'b001, 18'h2AAAA);
      void'(model_frame_start());
      frame_begin();
      for (int i = 0; i < 10; i++) shift_bit(w[23-i], b);
      resetn = 1'b0;
      model_reset();
      wait_clks(8);
      checks++;
      if (vout !== 18'd0) begin
         errors++; $display("[TB] FAIL resetn_vout: got %h expected %h", vout, 18'd0);
      end
      resetn = 1'b1;
      wait_clks(6);
      for (int i = 10; i < 24; i++) shift_bit(w[23-i], b);
      frame_end();
      xfer(24'hA00000, 24, e, g);
      xfer(24'h000000, 24, e, g);
      checks++;
      if (g !== 24'hA0000C || g !== e) begin
         errors++; $display("[TB] FAIL resetn_ctrl: got %h expected %h", g, 24'hA0000C);
      end
      code = 18'($urandom);
      xfer(24'h200002, 24, e, g);
      xfer(wr_code(3'b001, code), 24, e, g);
      checks++;
      if (vout !== code || vout !== model_vout()) begin
         errors++; $display("[TB] FAIL resetn_after: got %h expected %h", vout, code);
      end
   endtask

   initial begin
      rst = 1'b1; sdin = 1'b0; sclk = 1'b1; syncn = 1'b1;
      ldacn = 1'b1; clrn = 1'b1; resetn = 1'b1;
      model_reset();
      test_reset();
      test_control_write();
      test_direct_load();
      test_ldac_pin();
      test_short_frame();
      test_clear();
      test_sdodis();
      test_sw_control();
      test_random();
      test_resetn_midframe();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
